// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared definitions for the GEMM tile sequencer: FSM state encoding and
// the fixed SRAM read latency the strobe pipelines are built around.
package gemm_tile_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } seq_state_e;

   localparam int unsigned ReadLatency = 1;
   localparam int unsigned DrainCycles = 2;

endpackage

// File: rtl/gemm_tile_counter.sv
// Nested mt/nt/kt tile counter (kt innermost). Each counter wraps to 0 at its
// count minus 1 and carries into the next level out.
module gemm_tile_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             step_i,
   input  logic [Width-1:0] m_cnt_i,
   input  logic [Width-1:0] n_cnt_i,
   input  logic [Width-1:0] k_cnt_i,
   output logic [Width-1:0] mt_o,
   output logic [Width-1:0] nt_o,
   output logic [Width-1:0] kt_o,
   output logic             k_first_o,
   output logic             k_last_o,
   output logic             last_o
);

   logic [Width-1:0] mt_q, mt_d;
   logic [Width-1:0] nt_q, nt_d;
   logic [Width-1:0] kt_q, kt_d;
   logic             m_last, n_last, k_last;

   assign m_last = (mt_q == m_cnt_i - Width'(1));
   assign n_last = (nt_q == n_cnt_i - Width'(1));
   assign k_last = (kt_q == k_cnt_i - Width'(1));

   always_comb begin
      mt_d = mt_q;
      nt_d = nt_q;
      kt_d = kt_q;
      if (clear_i) begin
         mt_d = '0;
         nt_d = '0;
         kt_d = '0;
      end else if (step_i) begin
         if (k_last) begin
            kt_d = '0;
            if (n_last) begin
               nt_d = '0;
               mt_d = m_last ? '0 : mt_q + Width'(1);
            end else begin
               nt_d = nt_q + Width'(1);
            end
         end else begin
            kt_d = kt_q + Width'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mt_q <= '0;
         nt_q <= '0;
         kt_q <= '0;
      end else begin
         mt_q <= mt_d;
         nt_q <= nt_d;
         kt_q <= kt_d;
      end
   end

   assign mt_o      = mt_q;
   assign nt_o      = nt_q;
   assign kt_o      = kt_q;
   assign k_first_o = (kt_q == '0);
   assign k_last_o  = k_last;
   assign last_o    = m_last && n_last && k_last;

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Walks the mt/nt/kt tile loops of one GEMM job, driving SRAM A/B/C addresses
// and the PE valid/init/clear strobes, with abort and size checking.
module gemm_tile_sequencer
   import gemm_tile_sequencer_pkg::*;
#(
   parameter int unsigned SizeAddrWidth = 8,
   parameter int unsigned AddrWidth     = 16,
   parameter int unsigned M             = 4,
   parameter int unsigned N             = 4,
   parameter int unsigned K             = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [SizeAddrWidth-1:0] M_size_i,
   input  logic [SizeAddrWidth-1:0] K_size_i,
   input  logic [SizeAddrWidth-1:0] N_size_i,
   input  logic                     abort_i,
   output logic [AddrWidth-1:0]     sram_a_addr_o,
   output logic [AddrWidth-1:0]     sram_b_addr_o,
   output logic [AddrWidth-1:0]     sram_c_addr_o,
   output logic                     pe_valid_o,
   output logic                     pe_init_o,
   output logic                     pe_clr_o,
   output logic                     sram_c_we_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);

   localparam int unsigned WeDelay = ReadLatency + 1;

   seq_state_e                         state_q, state_d;
   logic                               drain_q, drain_d;
   logic                               err_q, err_d;
   logic [SizeAddrWidth-1:0]           mt_cnt_q, mt_cnt_d;
   logic [SizeAddrWidth-1:0]           nt_cnt_q, nt_cnt_d;
   logic [SizeAddrWidth-1:0]           kt_cnt_q, kt_cnt_d;
   logic [ReadLatency-1:0]             vld_pipe_q, vld_pipe_d;
   logic [ReadLatency-1:0]             init_pipe_q, init_pipe_d;
   logic [WeDelay-1:0]                 we_pipe_q, we_pipe_d;
   logic [WeDelay-1:0][AddrWidth-1:0]  c_addr_pipe_q, c_addr_pipe_d;

   logic                     handshake, sizes_ok, kill, issue, cnt_clear;
   logic [SizeAddrWidth-1:0] mt, nt, kt;
   logic                     k_first, k_last, last_step;
   logic [AddrWidth-1:0]     c_addr_issue;

   assign cmd_ready_o = (state_q == StIdle);
   assign handshake   = cmd_valid_i && cmd_ready_o;
   assign sizes_ok    = (M_size_i != '0) && ((M_size_i % SizeAddrWidth'(M)) == '0) &&
                        (K_size_i != '0) && ((K_size_i % SizeAddrWidth'(K)) == '0) &&
                        (N_size_i != '0) && ((N_size_i % SizeAddrWidth'(N)) == '0);
   // Abort only matters while a job is live; in IDLE/DONE it is a no-op.
   assign kill        = abort_i && ((state_q == StRun) || (state_q == StDrain));
   assign issue       = (state_q == StRun) && !abort_i;
   assign cnt_clear   = handshake || kill;

   gemm_tile_counter #(
      .Width (SizeAddrWidth)
   ) u_tile_counter (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (cnt_clear),
      .step_i    (issue),
      .m_cnt_i   (mt_cnt_q),
      .n_cnt_i   (nt_cnt_q),
      .k_cnt_i   (kt_cnt_q),
      .mt_o      (mt),
      .nt_o      (nt),
      .kt_o      (kt),
      .k_first_o (k_first),
      .k_last_o  (k_last),
      .last_o    (last_step)
   );

   assign sram_a_addr_o = AddrWidth'(mt) * AddrWidth'(kt_cnt_q) + AddrWidth'(kt);
   assign sram_b_addr_o = AddrWidth'(kt) * AddrWidth'(nt_cnt_q) + AddrWidth'(nt);
   assign c_addr_issue  = AddrWidth'(mt) * AddrWidth'(nt_cnt_q) + AddrWidth'(nt);

   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      err_d    = 1'b0;
      mt_cnt_d = mt_cnt_q;
      nt_cnt_d = nt_cnt_q;
      kt_cnt_d = kt_cnt_q;
      unique case (state_q)
         StIdle: begin
            drain_d = 1'b0;
            if (handshake) begin
               if (sizes_ok) begin
                  state_d  = StRun;
                  mt_cnt_d = M_size_i / SizeAddrWidth'(M);
                  nt_cnt_d = N_size_i / SizeAddrWidth'(N);
                  kt_cnt_d = K_size_i / SizeAddrWidth'(K);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (last_step) begin
               state_d = StDrain;
               drain_d = 1'b0;
            end
         end
         StDrain: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (drain_q == 1'(DrainCycles - 1)) begin
               state_d = StDone;
               drain_d = 1'b0;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Strobe pipelines track each issue through the SRAM read latency; a kill
   // empties them so nothing from an aborted job reaches the PEs or C SRAM.
   always_comb begin
      vld_pipe_d       = '0;
      init_pipe_d      = '0;
      we_pipe_d        = '0;
      c_addr_pipe_d    = '0;
      vld_pipe_d[0]    = issue;
      init_pipe_d[0]   = issue && k_first;
      we_pipe_d[0]     = issue && k_last;
      c_addr_pipe_d[0] = c_addr_issue;
      for (int unsigned i = 1; i < ReadLatency; i++) begin
         vld_pipe_d[i]  = vld_pipe_q[i-1];
         init_pipe_d[i] = init_pipe_q[i-1];
      end
      for (int unsigned i = 1; i < WeDelay; i++) begin
         we_pipe_d[i]     = we_pipe_q[i-1];
         c_addr_pipe_d[i] = c_addr_pipe_q[i-1];
      end
      if (kill) begin
         vld_pipe_d  = '0;
         init_pipe_d = '0;
         we_pipe_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         drain_q       <= 1'b0;
         err_q         <= 1'b0;
         mt_cnt_q      <= '0;
         nt_cnt_q      <= '0;
         kt_cnt_q      <= '0;
         vld_pipe_q    <= '0;
         init_pipe_q   <= '0;
         we_pipe_q     <= '0;
         c_addr_pipe_q <= '0;
      end else begin
         state_q       <= state_d;
         drain_q       <= drain_d;
         err_q         <= err_d;
         mt_cnt_q      <= mt_cnt_d;
         nt_cnt_q      <= nt_cnt_d;
         kt_cnt_q      <= kt_cnt_d;
         vld_pipe_q    <= vld_pipe_d;
         init_pipe_q   <= init_pipe_d;
         we_pipe_q     <= we_pipe_d;
         c_addr_pipe_q <= c_addr_pipe_d;
      end
   end

   assign pe_valid_o    = vld_pipe_q[ReadLatency-1];
   assign pe_init_o     = init_pipe_q[ReadLatency-1];
   assign sram_c_we_o   = we_pipe_q[WeDelay-1];
   assign sram_c_addr_o = c_addr_pipe_q[WeDelay-1];
   assign pe_clr_o      = (state_q == StIdle);
   assign busy_o        = (state_q == StRun) || (state_q == StDrain);
   assign done_o        = (state_q == StDone);
   assign err_o         = err_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer: per-cycle traces of each job are
// compared against hand-computed schedules (handshake cycle = cycle 0).
module tb_gemm_tile_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [7:0]  M_size_i, K_size_i, N_size_i;
   logic        abort_i;
   logic [15:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
   logic        pe_valid_o, pe_init_o, pe_clr_o, sram_c_we_o;
   logic        busy_o, done_o, err_o;

   int total = 0;
   int bad   = 0;

   logic        r_vld[32], r_init[32], r_we[32], r_done[32], r_err[32];
   logic        r_busy[32], r_ready[32], r_clr[32];
   logic [15:0] r_a[32], r_b[32], r_c[32];

   always #5 clk_i = ~clk_i;

   gemm_tile_sequencer #(
      .SizeAddrWidth (8),
      .AddrWidth     (16),
      .M             (4),
      .N             (4),
      .K             (4)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .M_size_i      (M_size_i),
      .K_size_i      (K_size_i),
      .N_size_i      (N_size_i),
      .abort_i       (abort_i),
      .sram_a_addr_o (sram_a_addr_o),
      .sram_b_addr_o (sram_b_addr_o),
      .sram_c_addr_o (sram_c_addr_o),
      .pe_valid_o    (pe_valid_o),
      .pe_init_o     (pe_init_o),
      .pe_clr_o      (pe_clr_o),
      .sram_c_we_o   (sram_c_we_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o)
   );

   // Inputs are driven just after the falling edge; outputs sampled 1ns later.
   task automatic run_job(input logic [7:0] ms, input logic [7:0] ks, input logic [7:0] ns,
                          input int ncyc, input int abort_at, input int valid_at,
                          input int rst_lo, input int rst_hi);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk_i);
         cmd_valid_i = (c == 0) || (c == valid_at);
         M_size_i    = (c == 0) ? ms : 8'($urandom_range(0, 255));
         K_size_i    = (c == 0) ? ks : 8'($urandom_range(0, 255));
         N_size_i    = (c == 0) ? ns : 8'($urandom_range(0, 255));
         abort_i     = (c == abort_at);
         rst_ni      = !((c >= rst_lo) && (c <= rst_hi));
         #1;
         r_vld[c]  = pe_valid_o;   r_init[c] = pe_init_o;  r_we[c]    = sram_c_we_o;
         r_done[c] = done_o;       r_err[c]  = err_o;      r_busy[c]  = busy_o;
         r_ready[c] = cmd_ready_o; r_clr[c]  = pe_clr_o;
         r_a[c] = sram_a_addr_o;   r_b[c] = sram_b_addr_o; r_c[c] = sram_c_addr_o;
      end
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      abort_i     = 1'b0;
      rst_ni      = 1'b1;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_reset();
      logic [15:0] got;
      rst_ni = 1'b0; cmd_valid_i = 1'b0; abort_i = 1'b0;
      M_size_i = 8'd0; K_size_i = 8'd0; N_size_i = 8'd0;
      repeat (2) @(negedge clk_i);
      #1;
      for (int i = 0; i < 11; i++) begin
         case (i)
            0: got = 16'(cmd_ready_o);   1: got = 16'(pe_clr_o);   2: got = 16'(busy_o);
            3: got = 16'(done_o);        4: got = 16'(err_o);      5: got = 16'(pe_valid_o);
            6: got = 16'(pe_init_o);     7: got = 16'(sram_c_we_o); 8: got = sram_c_addr_o;
            9: got = sram_a_addr_o;      default: got = sram_b_addr_o;
         endcase
         total++;
         if (got !== ((i < 2) ? 16'd1 : 16'd0)) begin
            bad++;
            $display("FAIL reset_out%0d got=%0h exp=%0h", i, got, (i < 2) ? 1 : 0);
         end
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_single();
      run_job(8'd4, 8'd4, 8'd4, 8, -1, -1, -1, -1);
      for (int c = 0; c < 8; c++) begin
         total += 6;
         if (r_vld[c]  !== (c == 2)) begin bad++; $display("FAIL single_vld c=%0d got=%0b", c, r_vld[c]); end
         if (r_init[c] !== (c == 2)) begin bad++; $display("FAIL single_init c=%0d got=%0b", c, r_init[c]); end
         if (r_we[c]   !== (c == 3)) begin bad++; $display("FAIL single_we c=%0d got=%0b", c, r_we[c]); end
         if (r_done[c] !== (c == 4)) begin bad++; $display("FAIL single_done c=%0d got=%0b", c, r_done[c]); end
         if (r_busy[c] !== (c >= 1 && c <= 3)) begin bad++; $display("FAIL single_busy c=%0d got=%0b", c, r_busy[c]); end
         if (r_ready[c] !== (c == 0 || c >= 5)) begin bad++; $display("FAIL single_ready c=%0d got=%0b", c, r_ready[c]); end
      end
      total += 3;
      if (r_a[1] !== 16'd0) begin bad++; $display("FAIL single_a got=%0d exp=0", r_a[1]); end
      if (r_b[1] !== 16'd0) begin bad++; $display("FAIL single_b got=%0d exp=0", r_b[1]); end
      if (r_c[3] !== 16'd0) begin bad++; $display("FAIL single_c got=%0d exp=0", r_c[3]); end
   endtask

   task automatic test_888();
      int a_tab[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
      int b_tab[8] = '{0, 2, 1, 3, 0, 2, 1, 3};
      run_job(8'd8, 8'd8, 8'd8, 14, -1, -1, -1, -1);
      for (int c = 0; c < 14; c++) begin
         total += 6;
         if (r_vld[c] !== (c >= 2 && c <= 9)) begin bad++; $display("FAIL b2b_vld c=%0d got=%0b", c, r_vld[c]); end
         if (r_init[c] !== (c == 2 || c == 4 || c == 6 || c == 8)) begin bad++; $display("FAIL b2b_init c=%0d got=%0b", c, r_init[c]); end
         if (r_we[c] !== (c == 4 || c == 6 || c == 8 || c == 10)) begin bad++; $display("FAIL b2b_we c=%0d got=%0b", c, r_we[c]); end
         if (r_done[c] !== (c == 11)) begin bad++; $display("FAIL b2b_done c=%0d got=%0b", c, r_done[c]); end
         if (r_busy[c] !== (c >= 1 && c <= 10)) begin bad++; $display("FAIL b2b_busy c=%0d got=%0b", c, r_busy[c]); end
         if (r_clr[c] !== (c == 0 || c >= 12)) begin bad++; $display("FAIL b2b_clr c=%0d got=%0b", c, r_clr[c]); end
         if (c >= 1 && c <= 8) begin
            total += 2;
            if (r_a[c] !== 16'(a_tab[c-1])) begin bad++; $display("FAIL b2b_a c=%0d got=%0d exp=%0d", c, r_a[c], a_tab[c-1]); end
            if (r_b[c] !== 16'(b_tab[c-1])) begin bad++; $display("FAIL b2b_b c=%0d got=%0d exp=%0d", c, r_b[c], b_tab[c-1]); end
         end
         if (c == 4 || c == 6 || c == 8 || c == 10) begin
            total++;
            if (r_c[c] !== 16'((c - 4) / 2)) begin bad++; $display("FAIL b2b_c c=%0d got=%0d exp=%0d", c, r_c[c], (c - 4) / 2); end
         end
      end
   endtask

   task automatic test_kt1();
      int a_tab[4] = '{0, 0, 1, 1};
      int b_tab[4] = '{0, 1, 0, 1};
      run_job(8'd8, 8'd4, 8'd8, 10, -1, -1, -1, -1);
      for (int c = 0; c < 10; c++) begin
         total += 4;
         if (r_vld[c]  !== (c >= 2 && c <= 5)) begin bad++; $display("FAIL kt1_vld c=%0d got=%0b", c, r_vld[c]); end
         if (r_init[c] !== (c >= 2 && c <= 5)) begin bad++; $display("FAIL kt1_init c=%0d got=%0b", c, r_init[c]); end
         if (r_we[c]   !== (c >= 3 && c <= 6)) begin bad++; $display("FAIL kt1_we c=%0d got=%0b", c, r_we[c]); end
         if (r_done[c] !== (c == 7)) begin bad++; $display("FAIL kt1_done c=%0d got=%0b", c, r_done[c]); end
         if (c >= 1 && c <= 4) begin
            total += 2;
            if (r_a[c] !== 16'(a_tab[c-1])) begin bad++; $display("FAIL kt1_a c=%0d got=%0d exp=%0d", c, r_a[c], a_tab[c-1]); end
            if (r_b[c] !== 16'(b_tab[c-1])) begin bad++; $display("FAIL kt1_b c=%0d got=%0d exp=%0d", c, r_b[c], b_tab[c-1]); end
         end
         if (c >= 3 && c <= 6) begin
            total++;
            if (r_c[c] !== 16'(c - 3)) begin bad++; $display("FAIL kt1_c c=%0d got=%0d exp=%0d", c, r_c[c], c - 3); end
         end
      end
   endtask

   task automatic test_err();
      run_job(8'd6, 8'd4, 8'd4, 6, -1, -1, -1, -1);
      for (int c = 0; c < 6; c++) begin
         total += 5;
         if (r_err[c] !== (c == 1)) begin bad++; $display("FAIL err_pulse c=%0d got=%0b", c, r_err[c]); end
         if (r_ready[c] !== 1'b1) begin bad++; $display("FAIL err_ready c=%0d got=%0b exp=1", c, r_ready[c]); end
         if ((r_vld[c] | r_init[c] | r_we[c]) !== 1'b0) begin bad++; $display("FAIL err_strobe c=%0d got=1 exp=0", c); end
         if (r_busy[c] !== 1'b0) begin bad++; $display("FAIL err_busy c=%0d got=%0b exp=0", c, r_busy[c]); end
         if (r_done[c] !== 1'b0) begin bad++; $display("FAIL err_done c=%0d got=%0b exp=0", c, r_done[c]); end
      end
   endtask

   task automatic test_ignore_valid();
      int n_we = 0;
      int n_done = 0;
      run_job(8'd8, 8'd8, 8'd8, 16, -1, 3, -1, -1);
      for (int c = 0; c < 16; c++) begin
         n_we   += int'(r_we[c]);
         n_done += int'(r_done[c]);
      end
      total += 4;
      if (n_we !== 4) begin bad++; $display("FAIL ignore_we_count got=%0d exp=4", n_we); end
      if (n_done !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
      if (r_done[11] !== 1'b1) begin bad++; $display("FAIL ignore_done_cycle got=%0b exp=1", r_done[11]); end
      if (r_busy[13] !== 1'b0) begin bad++; $display("FAIL ignore_busy_after got=%0b exp=0", r_busy[13]); end
   endtask

   task automatic test_abort();
      run_job(8'd8, 8'd8, 8'd8, 14, 5, -1, -1, -1);
      total += 2;
      if (r_vld[5] !== 1'b1) begin bad++; $display("FAIL abort_vld5 got=%0b exp=1", r_vld[5]); end
      if (r_we[4] !== 1'b1) begin bad++; $display("FAIL abort_we4 got=%0b exp=1", r_we[4]); end
      for (int c = 6; c < 14; c++) begin
         total += 5;
         if (r_ready[c] !== 1'b1) begin bad++; $display("FAIL abort_ready c=%0d got=%0b exp=1", c, r_ready[c]); end
         if (r_busy[c] !== 1'b0) begin bad++; $display("FAIL abort_busy c=%0d got=%0b exp=0", c, r_busy[c]); end
         if (r_we[c] !== 1'b0) begin bad++; $display("FAIL abort_we c=%0d got=%0b exp=0", c, r_we[c]); end
         if ((r_vld[c] | r_init[c]) !== 1'b0) begin bad++; $display("FAIL abort_vld c=%0d got=1 exp=0", c); end
         if (r_done[c] !== 1'b0) begin bad++; $display("FAIL abort_done c=%0d got=%0b exp=0", c, r_done[c]); end
      end
   endtask

   task automatic test_abort_last();
      run_job(8'd4, 8'd4, 8'd4, 7, 1, -1, -1, -1);
      for (int c = 2; c < 7; c++) begin
         total += 3;
         if ((r_vld[c] | r_init[c] | r_we[c]) !== 1'b0) begin bad++; $display("FAIL abortlast_strobe c=%0d got=1 exp=0", c); end
         if (r_done[c] !== 1'b0) begin bad++; $display("FAIL abortlast_done c=%0d got=%0b exp=0", c, r_done[c]); end
         if (r_ready[c] !== 1'b1) begin bad++; $display("FAIL abortlast_ready c=%0d got=%0b exp=1", c, r_ready[c]); end
      end
   endtask

   task automatic test_abort_idle();
      run_job(8'd4, 8'd4, 8'd4, 7, 0, -1, -1, -1);
      total += 3;
      if (r_busy[1] !== 1'b1) begin bad++; $display("FAIL abortidle_busy got=%0b exp=1", r_busy[1]); end
      if (r_we[3] !== 1'b1) begin bad++; $display("FAIL abortidle_we got=%0b exp=1", r_we[3]); end
      if (r_done[4] !== 1'b1) begin bad++; $display("FAIL abortidle_done got=%0b exp=1", r_done[4]); end
   endtask

   task automatic test_reset_mid();
      run_job(8'd8, 8'd8, 8'd8, 10, -1, -1, 4, 5);
      total += 6;
      if (r_ready[4] !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", r_ready[4]); end
      if (r_clr[4] !== 1'b1) begin bad++; $display("FAIL rstmid_clr got=%0b exp=1", r_clr[4]); end
      if ((r_busy[4] | r_vld[4] | r_init[4] | r_we[4] | r_err[4]) !== 1'b0) begin bad++; $display("FAIL rstmid_strobes got=1 exp=0"); end
      if (r_c[4] !== 16'd0) begin bad++; $display("FAIL rstmid_caddr got=%0d exp=0", r_c[4]); end
      if ((r_a[4] | r_b[4]) !== 16'd0) begin bad++; $display("FAIL rstmid_ab got=%0h exp=0", r_a[4] | r_b[4]); end
      begin
         int n_done = 0;
         for (int c = 0; c < 10; c++) n_done += int'(r_done[c]);
         if (n_done !== 0) begin bad++; $display("FAIL rstmid_done got=%0d exp=0", n_done); end
      end
      test_single();
   endtask

   initial begin
      test_reset();
      test_single();
      test_888();
      test_kt1();
      test_err();
      test_ignore_valid();
      test_abort();
      test_abort_last();
      test_abort_idle();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gemm_tile_sequencer.md
GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 SHALL have parameter SizeAddrWidth, default 8, which is the width of the matrix-size inputs and tile counters.
REQ-002 SHALL have parameter AddrWidth, default 16, which is the width of the SRAM address outputs.
REQ-003 SHALL have parameters M, N, K, each default 4, which are the tile dimensions of the PE array.
REQ-004 SHALL have ports, one per line:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  job request.
- cmd_ready_o  out  1  sequencer can accept a job.
- M_size_i, K_size_i, N_size_i  in  SizeAddrWidth each  job dimensions, sampled on handshake.
- abort_i  in  1  cancel the running job.
- sram_a_addr_o, sram_b_addr_o, sram_c_addr_o  out  AddrWidth each  tile addresses.
- pe_valid_o  out  1  operands on the SRAM read data are valid for the PEs.
- pe_init_o  out  1  first K-step of an output tile (PE restarts accumulation).
- pe_clr_o  out  1  clear the PE accumulators.
- sram_c_we_o  out  1  C tile write strobe.
- busy_o  out  1  job in progress.
- done_o  out  1  job-complete pulse.
- err_o  out  1  rejected-job pulse.

Function
REQ-005 A job SHALL be accepted when cmd_valid_i and cmd_ready_o are both high; cmd_ready_o SHALL be high only in IDLE.
REQ-006 On acceptance, the sequencer SHALL latch the tile counts Mt=M_size_i/M, Kt=K_size_i/K and Nt=N_size_i/N.
REQ-007 If any size is zero or not a multiple of its tile dimension, the sequencer SHALL pulse err_o for 1 cycle the cycle after the handshake, stay in IDLE, and issue no strobes.
REQ-008 The state machine SHALL have states IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE->RUN on a valid handshake.
- RUN->DRAIN after issuing the last step.
- DRAIN->DONE after 2 cycles.
- DONE->IDLE after 1 cycle.
REQ-009 In RUN, the sequencer SHALL issue one step per cycle, using loop order mt (outer), nt, kt (inner); all counters SHALL wrap to 0 at their count minus 1.
REQ-010 The issue-cycle addresses SHALL be combinational from the counters: A = mt*Kt + kt and B = kt*Nt + nt, both zero-extended to AddrWidth.
REQ-011 SRAM read latency SHALL be fixed at 1 cycle; pe_valid_o SHALL be high exactly 1 cycle after each issue cycle.
REQ-012 pe_init_o SHALL be high in the cycle after an issue with kt==0.
REQ-013 sram_c_we_o SHALL pulse 2 cycles after an issue with kt==Kt-1.
REQ-014 sram_c_addr_o SHALL equal mt*Nt + nt of that issue and SHALL be registered, so it is valid in the same cycle as sram_c_we_o.
REQ-015 pe_clr_o SHALL be high whenever the state is IDLE.
REQ-016 busy_o SHALL be high in RUN and DRAIN.
REQ-017 done_o SHALL be a 1-cycle pulse in DONE.
REQ-018 Total job cycles from the handshake to done_o SHALL be Mt*Nt*Kt + 3.
REQ-019 cmd_valid_i while not in IDLE SHALL be ignored (not queued).
REQ-020 Size inputs SHALL be ignored except on the handshake cycle.
REQ-021 abort_i in RUN or DRAIN SHALL force IDLE on the next edge and suppress all in-flight pe_valid_o, pe_init_o and sram_c_we_o; done_o SHALL NOT pulse for an aborted job.
REQ-022 abort_i in IDLE or DONE SHALL have no effect.
REQ-023 If abort_i coincides with the last issue, abort SHALL win.
REQ-024 Kt==1 SHALL assert pe_init_o and the sram_c_we_o pulse for every output tile (one tile per pulse).
REQ-025 Address arithmetic SHALL be unsigned and truncated to AddrWidth without saturation.

Reset
REQ-026 While rst_ni is low, the sequencer SHALL be in IDLE with all counters 0, sram_c_addr_o=0, and every strobe output 0 except cmd_ready_o=1 and pe_clr_o=1.
REQ-027 Reset asserted mid-job SHALL discard the job with no done_o and no err_o; after release the block SHALL accept a new job 1 cycle later.

Structure
REQ-028 The state enum (IDLE/RUN/DRAIN/DONE) and the fixed read-latency constant (1) SHALL live in the shared gemm package.
REQ-029 One sub-module, gemm_tile_counter (a nested 3-level wrapping counter with step/clear/last outputs), SHALL be instantiated; the remainder SHALL be inline.

Verification
REQ-030 Sizes 4/4/4 with M=N=K=4 -> 1 issue; A=0, B=0; pe_init_o and pe_valid_o at cycle 2; sram_c_we_o at cycle 3 with C=0; done_o at cycle 4 (handshake=cycle 0).
REQ-031 Sizes 8/8/8 -> 8 issues in cycles 1-8; sram_c_we_o at cycles 4, 6, 8, 10 with C=0, 1, 2, 3; A sequence 0,1,0,1,2,3,2,3; done_o at cycle 11.
REQ-032 M_size_i=6 (others 4) -> err_o pulse at cycle 1; cmd_ready_o stays high; no strobes.
REQ-033 cmd_valid_i raised at cycle 3 of an 8/8/8 job -> ignored; exactly 4 C writes occur and one done_o.
REQ-034 abort_i at cycle 5 of an 8/8/8 job -> IDLE at cycle 6; no sram_c_we_o after cycle 5; no done_o.
REQ-035 rst_ni low at cycle 4 of an 8/8/8 job -> all outputs at their reset values; a new 4/4/4 job then completes normally.
